// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer write path.
package fb_pkg;

    localparam int FB_WIDTH_DFLT  = 400;
    localparam int FB_HEIGHT_DFLT = 240;
    localparam int FB_WORDS       = FB_WIDTH_DFLT * FB_HEIGHT_DFLT;

    typedef logic [8:0] pixel_t;

    typedef enum logic [1:0] {
        WAIT_READY,
        DRAW,
        FLUSH
    } fba_state_e;

    // Row-major linear index, evaluated in 32-bit unsigned arithmetic.
    function automatic logic [31:0] xy_to_index(input logic [8:0]  x,
                                                input logic [7:0]  y,
                                                input logic [31:0] width);
        return 32'(y) * width + 32'(x);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr) + off) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame-store pixel-write port between drawing engines.
// Optional per-frame pixel statistics are enabled by defining FBA_STATS_EN.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int FB_WIDTH  = FB_WIDTH_DFLT,
    parameter  int FB_HEIGHT = FB_HEIGHT_DFLT,
    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*9-1:0]   req_x,
    input  logic [NUM_REQ*8-1:0]   req_y,
    input  logic [NUM_REQ*9-1:0]   req_color,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   fb_ready,
    output logic [31:0]            fb_index,
    output pixel_t                 fb_data,
    output logic                   fb_loaded,
    output logic                   frame_done
`ifdef FBA_STATS_EN
    ,
    output logic [31:0]            stat_written,
    output logic [31:0]            stat_dropped,
    output logic [31:0]            stat_written_last,
    output logic [31:0]            stat_dropped_last
`endif
);

    fba_state_e state, state_nx;

    logic [PW-1:0]              rr_ptr;
    logic [NUM_REQ-1:0]         done_mask;
    logic                       seen_first;
    logic                       pix_pend;

    logic [NUM_REQ-1:0][8:0]    x_arr;
    logic [NUM_REQ-1:0][7:0]    y_arr;
    logic [NUM_REQ-1:0][8:0]    c_arr;

    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         grant_raw;
    logic                       grant_en;
    logic [PW-1:0]              gidx;
    logic [PW-1:0]              next_ptr;
    logic                       hs;
    logic                       sel_last;
    logic [8:0]                 sel_x;
    logic [7:0]                 sel_y;
    pixel_t                     sel_color;
    logic                       in_bounds;
    logic                       pix_go;
    logic                       pix_drop;
    logic                       frame_start;

    assign x_arr = req_x;
    assign y_arr = req_y;
    assign c_arr = req_color;

    // Engines that already flagged last stay masked until the swap completes.
    assign eligible = req_valid & ~done_mask;
    assign grant_en = (state == DRAW) && fb_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant_raw)
    );

    assign req_ready = grant_en ? grant_raw : '0;
    assign hs        = |req_ready;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) gidx = PW'(i);
        end
    end

    assign next_ptr  = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign sel_last  = req_last[gidx];
    assign sel_x     = x_arr[gidx];
    assign sel_y     = y_arr[gidx];
    assign sel_color = c_arr[gidx];
    assign in_bounds = (32'(sel_x) < 32'(FB_WIDTH)) && (32'(sel_y) < 32'(FB_HEIGHT));
    assign pix_go    = hs && !sel_last && in_bounds;
    assign pix_drop  = hs && !sel_last && !in_bounds;

    assign frame_start = (state == WAIT_READY) && fb_ready;

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_READY: if (fb_ready) state_nx = DRAW;
            // Hold off the flush until the last written pixel has been presented.
            DRAW:       if (&done_mask && !pix_pend) state_nx = FLUSH;
            FLUSH:      if (!fb_ready) state_nx = WAIT_READY;
            default:    state_nx = WAIT_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_READY;
            rr_ptr     <= '0;
            done_mask  <= '0;
            seen_first <= 1'b0;
            pix_pend   <= 1'b0;
            fb_index   <= '0;
            fb_data    <= '0;
            fb_loaded  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            fb_loaded  <= (state_nx == FLUSH);
            frame_done <= frame_start && seen_first;
            pix_pend   <= pix_go;
            if (frame_start) seen_first <= 1'b1;
            if (hs) rr_ptr <= next_ptr;
            if (hs && sel_last) done_mask[gidx] <= 1'b1;
            if (pix_go) begin
                fb_index <= xy_to_index(sel_x, sel_y, 32'(FB_WIDTH));
                fb_data  <= sel_color;
            end
            if (state == FLUSH && !fb_ready) done_mask <= '0;
        end
    end

`ifdef FBA_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_written      <= '0;
            stat_dropped      <= '0;
            stat_written_last <= '0;
            stat_dropped_last <= '0;
        end else if (frame_start && seen_first) begin
            stat_written_last <= stat_written;
            stat_dropped_last <= stat_dropped;
            stat_written      <= '0;
            stat_dropped      <= '0;
        end else begin
            if (pix_go)   stat_written <= stat_written + 32'd1;
            if (pix_drop) stat_dropped <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (3 engines, 400x240 buffer).
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [26:0] req_x;
    logic [23:0] req_y;
    logic [26:0] req_color;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        fb_ready;
    logic [31:0] fb_index;
    logic [8:0]  fb_data;
    logic        fb_loaded;
    logic        frame_done;
`ifdef FBA_STATS_EN
    logic [31:0] stat_written, stat_dropped, stat_written_last, stat_dropped_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.NUM_REQ(3), .FB_WIDTH(400), .FB_HEIGHT(240)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fb_ready   (fb_ready),
        .fb_index   (fb_index),
        .fb_data    (fb_data),
        .fb_loaded  (fb_loaded),
        .frame_done (frame_done)
`ifdef FBA_STATS_EN
        ,
        .stat_written      (stat_written),
        .stat_dropped      (stat_dropped),
        .stat_written_last (stat_written_last),
        .stat_dropped_last (stat_dropped_last)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [8:0] x,
                           input logic [7:0] y, input logic [8:0] c, input logic l);
        req_valid[i]       = v;
        req_x[9*i +: 9]    = x;
        req_y[8*i +: 8]    = y;
        req_color[9*i +: 9] = c;
        req_last[i]        = l;
    endtask

    initial begin
        logic [2:0] exp_g;
        int g;

        reset = 1'b1; fb_ready = 1'b0;
        req_valid = '0; req_x = '0; req_y = '0; req_color = '0; req_last = '0;
        tick; tick;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_index", fb_index, 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_loaded", 32'(fb_loaded), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        // First WAIT_READY->DRAW: no frame_done pulse.
        reset = 1'b0; fb_ready = 1'b1;
        tick;
        chk("first_frame_done", 32'(frame_done), 0);

        // Single engine, corner pixels.
        set_req(0, 1, 9'd0, 8'd0, 9'h1FF, 0); #1;
        chk("p0_ready", 32'(req_ready), 3'b001);
        tick;
        chk("p0_index", fb_index, 0);
        chk("p0_data", 32'(fb_data), 9'h1FF);
        set_req(0, 1, 9'd399, 8'd239, 9'h0AA, 0); #1;
        chk("p1_ready", 32'(req_ready), 3'b001);
        tick;
        chk("p1_index", fb_index, 95999);
        chk("p1_data", 32'(fb_data), 9'h0AA);
        set_req(0, 1, 9'd5, 8'd2, 9'h055, 0);
        tick;
        chk("p2_index", fb_index, 805);
        chk("p2_data", 32'(fb_data), 9'h055);
        req_valid = '0;

        // All three engines pending: rr_ptr is 1 after engine 0's grants.
        for (int i = 0; i < 3; i++) set_req(i, 1, 9'(10 + i), 8'd1, 9'(16 + i), 0);
        for (int k = 0; k < 6; k++) begin
            #1;
            g = (1 + k) % 3;
            exp_g = '0; exp_g[g] = 1'b1;
            chk("rr_grant", 32'(req_ready), 32'(exp_g));
            tick;
            chk("rr_index", fb_index, 32'(410 + g));
        end
        req_valid = '0;

        // Out-of-bounds pixels are consumed without a write.
        set_req(1, 1, 9'd400, 8'd10, 9'h1AB, 0); #1;
        chk("oob_x_ready", 32'(req_ready), 3'b010);
        tick;
        chk("oob_x_index", fb_index, 410);
        chk("oob_x_data", 32'(fb_data), 16);
        set_req(1, 1, 9'd3, 8'd240, 9'h1AC, 0); #1;
        chk("oob_y_ready", 32'(req_ready), 3'b010);
        tick;
        chk("oob_y_index", fb_index, 410);
        chk("oob_y_data", 32'(fb_data), 16);
        req_valid = '0;
`ifdef FBA_STATS_EN
        chk("stat_dropped", stat_dropped, 2);
        chk("stat_written", stat_written, 9);
`endif

        // fb_ready low in DRAW stalls everything; rr_ptr stays at 2.
        set_req(0, 1, 9'd0, 8'd5, 9'h011, 0);
        set_req(1, 1, 9'd1, 8'd5, 9'h022, 0);
        set_req(2, 1, 9'd7, 8'd3, 9'h077, 0);
        fb_ready = 1'b0; #1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_ready", 32'(req_ready), 0);
            tick;
        end
        fb_ready = 1'b1; #1;
        chk("resume_ready", 32'(req_ready), 3'b100);
        tick;
        chk("resume_index", fb_index, 1207);
        chk("resume_data", 32'(fb_data), 9'h077);
        req_valid = '0;

        // Engine 2's final pixel, then every engine flags last.
        set_req(2, 1, 9'd9, 8'd9, 9'h123, 0); #1;
        chk("lastpix_ready", 32'(req_ready), 3'b100);
        tick;
        chk("lastpix_index", fb_index, 3609);
        chk("lastpix_data", 32'(fb_data), 9'h123);
        for (int i = 0; i < 3; i++) set_req(i, 1, 9'd0, 8'd0, 9'h000, 1);
        #1;
        chk("last0_ready", 32'(req_ready), 3'b001);
        tick;
        chk("last1_ready", 32'(req_ready), 3'b010);
        tick;
        chk("last2_ready", 32'(req_ready), 3'b100);
        tick;
        chk("masked_ready", 32'(req_ready), 0);
        chk("pre_flush_loaded", 32'(fb_loaded), 0);
        chk("last_no_write", fb_index, 3609);
        tick;
        chk("flush_loaded", 32'(fb_loaded), 1);
        tick; tick;
        chk("flush_hold_loaded", 32'(fb_loaded), 1);
        chk("flush_ready", 32'(req_ready), 0);
        fb_ready = 1'b0;
        tick;
        chk("unload", 32'(fb_loaded), 0);
        req_valid = '0; req_last = '0;
        for (int k = 0; k < 20; k++) tick;
        chk("clear_frame_done", 32'(frame_done), 0);
        fb_ready = 1'b1;
        tick;
        chk("swap_frame_done", 32'(frame_done), 1);
`ifdef FBA_STATS_EN
        chk("stat_written_last", stat_written_last, 11);
        chk("stat_dropped_last", stat_dropped_last, 2);
        chk("stat_written_zero", stat_written, 0);
`endif
        set_req(0, 1, 9'd1, 8'd1, 9'h00F, 0); #1;
        chk("newframe_ready", 32'(req_ready), 3'b001);
        tick;
        chk("pulse_end", 32'(frame_done), 0);
        chk("newframe_index", fb_index, 401);
        chk("newframe_data", 32'(fb_data), 9'h00F);

        // Reset while flushing.
        for (int i = 0; i < 3; i++) set_req(i, 1, 9'd0, 8'd0, 9'h000, 1);
        #1;
        chk("r_last_ready", 32'(req_ready), 3'b010);
        tick; tick; tick;
        tick;
        chk("r_flush_loaded", 32'(fb_loaded), 1);
        reset = 1'b1; fb_ready = 1'b0;
        tick;
        chk("r_loaded_clr", 32'(fb_loaded), 0);
        chk("r_index_clr", fb_index, 0);
        reset = 1'b0; req_valid = '0; req_last = '0;
        tick; tick; tick;
        chk("r_no_frame_done", 32'(frame_done), 0);
        chk("r_no_grant", 32'(req_ready), 0);
        fb_ready = 1'b1;
        tick;
        set_req(1, 1, 9'd2, 8'd2, 9'h0C3, 0); #1;
        chk("r_mask_clr_ready", 32'(req_ready), 3'b010);
        tick;
        chk("r_index", fb_index, 802);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
